signal_conflict_monitor: RTL and testbench
==========================================

# signal_conflict_monitor

Independent safety monitor that reads the twelve lamp outputs of the intersection controller (green/yellow/red for N, E, S, W) and checks them against the legal signalling rules. It sits beside `top` as the consumer of its lamp interface. On the first violation it latches a fault code and direction and drives a flashing-red override request for the cabinet lamp drivers. It never feeds back into the controller's timing.

## Interface
- `MIN_YELLOW`, default 3: minimum number of cycles yellow must stay lit before red.
- `FLASH_HALF`, default 8: half-period of `flash_red`, in cycles.
- `WATCHDOG_CYCLES`, default 1024: stall limit. Used only with `SCM_WATCHDOG_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `green_N`, `yellow_N`, `red_N` … `green_W`, `yellow_W`, `red_W` in 1 each: lamp outputs of the controller.
- `fault_clear` in 1: single-cycle request to clear a latched fault.
- `fault` out 1: latched fault.
- `fault_code` out 3: 0 none, 1 conflict, 2 invalid lamp, 3 illegal sequence, 4 short yellow, 5 watchdog.
- `fault_dir` out 2: offending direction, N=0, E=1, S=2, W=3.
- `flash_red` out 1: flashing-red override, valid while `fault`=1.

## Operation
- **Input capture:** lamps are registered into `lamp_q` every cycle. `lamp_p` holds the previous `lamp_q`. Checks run on `lamp_q` against `lamp_p`.
- **Conflict (code 1):** green or yellow on N or S in the same cycle as green or yellow on E or W. `fault_dir` is the lowest-index direction with green or yellow lit.
- **Invalid lamp (code 2):** a direction's {g,y,r} is not one-hot, i.e. none lit or more than one lit.
- **Illegal sequence (code 3):** any of these transitions in one direction: green→red, yellow→green, red→yellow. Legal transitions are red→green, green→yellow, yellow→red and no change.
- **Short yellow (code 4):**
  - Each direction has a yellow counter that increments while yellow is lit, saturates at `MIN_YELLOW`, and clears when yellow is not lit.
  - A fault fires on a yellow→red transition when the counter is below `MIN_YELLOW`.
- **Priority within one cycle:** code 1 > 2 > 3 > 4 > 5. Within a code, the lowest direction index wins.
- **Latch:**
  - The first violation sets `fault`, `fault_code` and `fault_dir`.
  - Later violations do not overwrite them while `fault`=1.
- **Clear:**
  - `fault_clear` clears all three outputs only if no violation is detected in that same cycle.
  - If clear and a violation coincide, the violation wins and the new code is latched.
- **Flash:**
  - On the cycle `fault` rises, `flash_red`=1. It then toggles every `FLASH_HALF` cycles.
  - `flash_red` is 0 whenever `fault`=0.
- **Counter widths:** `$clog2(MIN_YELLOW+1)`, `$clog2(FLASH_HALF)`, `$clog2(WATCHDOG_CYCLES+1)`.

## Timing
- **Reset values:**
  - `lamp_q` and `lamp_p` reset to all-red, so the first red→green after reset is legal.
  - Counters reset to 0.
  - `fault`, `fault_code`, `fault_dir` and `flash_red` reset to 0.
- **Latency:** a bad lamp vector present before rising edge k is captured at edge k. `fault` and its code are visible after edge k+1, two cycles of latency.
- **Clear latency:** an accepted `fault_clear` sampled at edge k gives `fault`=0 after edge k.
- **Short pulses:** a violation lasting one cycle is still latched.
- **Reset mid-fault:** all state returns to reset values in the same cycle. This is the only way, besides `fault_clear`, to drop a fault.

## Configuration
- **`SCM_WATCHDOG_EN` defined:**
  - A stall counter clears whenever `lamp_q` ≠ `lamp_p` and otherwise increments, saturating at `WATCHDOG_CYCLES`.
  - When it reaches `WATCHDOG_CYCLES`, code 5 latches with `fault_dir`=0.
- **`SCM_WATCHDOG_EN` undefined:** no counter logic exists and code 5 is never produced.

## Structure
- **Package `scm_pkg`:**
  - `lamp_t` struct {g, y, r}.
  - Fault code localparams `SCM_NONE` … `SCM_WDOG`.
  - Direction localparams `DIR_N` … `DIR_W`.
- **Sub-module `scm_lamp_tracker`:**
  - One instance per direction.
  - Holds the current and previous `lamp_t` and the yellow counter.
  - Outputs the per-direction `invalid`, `bad_seq`, `short_yel` and `active` (green or yellow lit) flags.
- **Top level:** conflict check, priority encoder, latch, flash and watchdog.

## Test plan
- **Legal cycle:** N green 10 cycles, yellow 3, red, then E green 10, yellow 3, red, repeated → `fault`=0 throughout.
- **Conflict:** `green_N`=`green_E`=1 → two cycles later `fault`=1, `fault_code`=1, `fault_dir`=0, `flash_red`=1. `flash_red` toggles every 8 cycles.
- **Invalid lamp:** W with `green_W`=`red_W`=1 → code 2, dir 3. In a separate run, S with all lamps off → code 2, dir 2.
- **Sequence and yellow:**
  - E green→red directly → code 3, dir 1.
  - S yellow held 2 cycles, then red → code 4, dir 2.
  - Yellow held exactly 3 cycles → no fault.
- **Clear:**
  - `fault_clear` after lamps are legal again → `fault`=0 next cycle.
  - `fault_clear` while the conflict persists → `fault` stays 1 with code 1.
  - `reset` pulse mid-fault → all outputs 0.
- **Watchdog (`SCM_WATCHDOG_EN`, `WATCHDOG_CYCLES`=16):**
  - Lamps frozen 16 cycles → code 5.
  - Any lamp change at cycle 15 → no fault.

Source files
------------

// File: rtl/scm_pkg.sv
// Shared types and constants for the signal conflict monitor.
// Contents:
//   lamp_t                       packed {g, y, r} lamp triple for one direction
//   SCM_NONE .. SCM_WDOG         3-bit fault codes reported on fault_code
//   DIR_N .. DIR_W               2-bit direction indices reported on fault_dir
//   lamp_one_hot()               true when exactly one lamp of a triple is lit
package scm_pkg;

  typedef struct packed {
    logic g;
    logic y;
    logic r;
  } lamp_t;

  localparam logic [2:0] SCM_NONE      = 3'd0;
  localparam logic [2:0] SCM_CONFLICT  = 3'd1;
  localparam logic [2:0] SCM_INVALID   = 3'd2;
  localparam logic [2:0] SCM_SEQ       = 3'd3;
  localparam logic [2:0] SCM_SHORT_YEL = 3'd4;
  localparam logic [2:0] SCM_WDOG      = 3'd5;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // All-red is the safe state the lamp history resets to.
  localparam lamp_t LAMP_RED = 3'b001;

  function automatic logic lamp_one_hot(lamp_t l);
    return (l.g & ~l.y & ~l.r) | (~l.g & l.y & ~l.r) | (~l.g & ~l.y & l.r);
  endfunction

endpackage

// File: rtl/scm_lamp_tracker.sv
// Per-direction lamp history and rule checks.
// Registers the incoming {g,y,r} triple into lamp_q, keeps the previous
// sample in lamp_p and counts how long yellow has been lit.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   lamp[2:0]     raw {green, yellow, red} lamp inputs of this direction
//   invalid       lamp_q is not one-hot (none lit or several lit)
//   bad_seq       lamp_p -> lamp_q is green->red, yellow->green or red->yellow
//   short_yel     yellow->red while the yellow counter is below MIN_YELLOW
//   active        green or yellow lit in lamp_q
//   changed       lamp_q differs from lamp_p (only with SCM_WATCHDOG_EN)
module scm_lamp_tracker
  import scm_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] lamp,
  output logic       invalid,
  output logic       bad_seq,
  output logic       short_yel,
  output logic       active
`ifdef SCM_WATCHDOG_EN
  , output logic     changed
`endif
);

  localparam int YW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;

  lamp_t          lamp_q;
  lamp_t          lamp_p;
  logic [YW-1:0]  yel_cnt;

  // yel_cnt follows lamp_q, so on the cycle red reaches lamp_q it holds the
  // number of cycles lamp_p was yellow.
  always_ff @(posedge clk) begin
    if (reset) begin
      lamp_q  <= LAMP_RED;
      lamp_p  <= LAMP_RED;
      yel_cnt <= '0;
    end else begin
      lamp_q <= lamp_t'(lamp);
      lamp_p <= lamp_q;
      if (!lamp_q.y)
        yel_cnt <= '0;
      else if (yel_cnt != YW'(MIN_YELLOW))
        yel_cnt <= yel_cnt + 1'b1;
    end
  end

  assign invalid   = ~lamp_one_hot(lamp_q);
  assign bad_seq   = (lamp_p.g & lamp_q.r) | (lamp_p.y & lamp_q.g) | (lamp_p.r & lamp_q.y);
  assign short_yel = lamp_p.y & lamp_q.r & (yel_cnt < YW'(MIN_YELLOW));
  assign active    = lamp_q.g | lamp_q.y;

`ifdef SCM_WATCHDOG_EN
  assign changed = (lamp_q != lamp_p);
`endif

endmodule

// File: rtl/signal_conflict_monitor.sv
// Independent safety monitor for the four-way intersection lamp outputs.
// Checks conflicting greens/yellows, invalid lamp combinations, illegal
// transitions and short yellows; latches the first fault and requests a
// flashing-red override. Optional stall watchdog under SCM_WATCHDOG_EN.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   green_X/yellow_X/red_X        controller lamps, X in N, E, S, W
//   fault_clear                   one-cycle request to drop a latched fault
//   fault                         latched fault flag
//   fault_code[2:0]               latched cause (see scm_pkg)
//   fault_dir[1:0]                offending direction N=0 E=1 S=2 W=3
//   flash_red                     flashing-red override, 0 while fault=0
// Macro: SCM_WATCHDOG_EN enables the stall watchdog (fault code 5).
module signal_conflict_monitor
  import scm_pkg::*;
#(
  parameter int MIN_YELLOW      = 3,
  parameter int FLASH_HALF      = 8,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       green_N,
  input  logic       yellow_N,
  input  logic       red_N,
  input  logic       green_E,
  input  logic       yellow_E,
  input  logic       red_E,
  input  logic       green_S,
  input  logic       yellow_S,
  input  logic       red_S,
  input  logic       green_W,
  input  logic       yellow_W,
  input  logic       red_W,
  input  logic       fault_clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic       flash_red
);

  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [2:0] lamp_in [4];
  logic [3:0] invalid;
  logic [3:0] bad_seq;
  logic [3:0] short_yel;
  logic [3:0] active;
  logic       wdog_hit;

  assign lamp_in[0] = {green_N, yellow_N, red_N};
  assign lamp_in[1] = {green_E, yellow_E, red_E};
  assign lamp_in[2] = {green_S, yellow_S, red_S};
  assign lamp_in[3] = {green_W, yellow_W, red_W};

`ifdef SCM_WATCHDOG_EN
  logic [3:0] changed;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dir
      scm_lamp_tracker #(
        .MIN_YELLOW (MIN_YELLOW)
      ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .lamp      (lamp_in[gi]),
        .invalid   (invalid[gi]),
        .bad_seq   (bad_seq[gi]),
        .short_yel (short_yel[gi]),
        .active    (active[gi])
`ifdef SCM_WATCHDOG_EN
        , .changed (changed[gi])
`endif
      );
    end
  endgenerate

`ifdef SCM_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WW-1:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (|changed)
      stall_cnt_reg <= '0;
    else if (stall_cnt_reg != WW'(WATCHDOG_CYCLES))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign wdog_hit = (stall_cnt_reg == WW'(WATCHDOG_CYCLES));
`else
  assign wdog_hit = 1'b0;
`endif

  function automatic logic [1:0] lowest_dir(logic [3:0] v);
    logic [1:0] d;
    d = DIR_N;
    for (int i = 3; i >= 0; i--)
      if (v[i]) d = 2'(i);
    return d;
  endfunction

  // Priority encoder: conflict > invalid > sequence > short yellow > watchdog.
  logic       viol;
  logic [2:0] viol_code;
  logic [1:0] viol_dir;

  always_comb begin
    viol      = 1'b1;
    viol_code = SCM_NONE;
    viol_dir  = DIR_N;
    if ((active[DIR_N] | active[DIR_S]) & (active[DIR_E] | active[DIR_W])) begin
      viol_code = SCM_CONFLICT;
      viol_dir  = lowest_dir(active);
    end else if (|invalid) begin
      viol_code = SCM_INVALID;
      viol_dir  = lowest_dir(invalid);
    end else if (|bad_seq) begin
      viol_code = SCM_SEQ;
      viol_dir  = lowest_dir(bad_seq);
    end else if (|short_yel) begin
      viol_code = SCM_SHORT_YEL;
      viol_dir  = lowest_dir(short_yel);
    end else if (wdog_hit) begin
      viol_code = SCM_WDOG;
      viol_dir  = DIR_N;
    end else begin
      viol = 1'b0;
    end
  end

  logic          fault_reg, fault_next;
  logic [2:0]    code_reg, code_next;
  logic [1:0]    dir_reg, dir_next;
  logic          flash_reg, flash_next;
  logic [FW-1:0] fcnt_reg, fcnt_next;

  always_comb begin
    fault_next = fault_reg;
    code_next  = code_reg;
    dir_next   = dir_reg;
    flash_next = flash_reg;
    fcnt_next  = fcnt_reg;

    // A violation in the clear cycle beats the clear and reloads the code.
    if (viol && (!fault_reg || fault_clear)) begin
      fault_next = 1'b1;
      code_next  = viol_code;
      dir_next   = viol_dir;
    end else if (fault_clear) begin
      fault_next = 1'b0;
      code_next  = SCM_NONE;
      dir_next   = DIR_N;
    end

    if (!fault_next) begin
      flash_next = 1'b0;
      fcnt_next  = '0;
    end else if (!fault_reg) begin
      flash_next = 1'b1;
      fcnt_next  = '0;
    end else if (fcnt_reg == FW'(FLASH_HALF - 1)) begin
      flash_next = ~flash_reg;
      fcnt_next  = '0;
    end else begin
      fcnt_next = fcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_reg <= 1'b0;
      code_reg  <= SCM_NONE;
      dir_reg   <= DIR_N;
      flash_reg <= 1'b0;
      fcnt_reg  <= '0;
    end else begin
      fault_reg <= fault_next;
      code_reg  <= code_next;
      dir_reg   <= dir_next;
      flash_reg <= flash_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  assign fault      = fault_reg;
  assign fault_code = code_reg;
  assign fault_dir  = dir_reg;
  assign flash_red  = flash_reg;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_signal_conflict_monitor;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic       fault_clear;
  logic [2:0] lamps [4];
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic       flash_red;

  int n_checks = 0;
  int n_errors = 0;
  logic fault_seen;

  always #5 clk = ~clk;

  signal_conflict_monitor #(
    .MIN_YELLOW      (3),
    .FLASH_HALF      (8),
    .WATCHDOG_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .green_N     (lamps[0][2]),
    .yellow_N    (lamps[0][1]),
    .red_N       (lamps[0][0]),
    .green_E     (lamps[1][2]),
    .yellow_E    (lamps[1][1]),
    .red_E       (lamps[1][0]),
    .green_S     (lamps[2][2]),
    .yellow_S    (lamps[2][1]),
    .red_S       (lamps[2][0]),
    .green_W     (lamps[3][2]),
    .yellow_W    (lamps[3][1]),
    .red_W       (lamps[3][0]),
    .fault_clear (fault_clear),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_dir   (fault_dir),
    .flash_red   (flash_red)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (fault) fault_seen = 1'b1;
  endtask

  task automatic all_red();
    for (int i = 0; i < 4; i++) lamps[i] = R;
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
  endtask

  task automatic chk_fault(input string tag, input int f, input int c, input int d);
    chk({tag, "_fault"}, int'(fault), f);
    chk({tag, "_code"}, int'(fault_code), c);
    chk({tag, "_dir"}, int'(fault_dir), d);
  endtask

  initial begin
    reset       = 1'b1;
    fault_clear = 1'b0;
    fault_seen  = 1'b0;
    all_red();
    tick();
    tick();
    chk_fault("reset", 0, 0, 0);
    chk("reset_flash", int'(flash_red), 0);
    reset = 1'b0;

`ifdef SCM_WATCHDOG_EN
    // Change a lamp every 15 cycles: stall counter never reaches 16.
    fault_seen = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int d = 0; d < 2; d++) begin
        lamps[d] = G; repeat (15) tick();
        lamps[d] = Y; repeat (15) tick();
        lamps[d] = R; repeat (15) tick();
      end
    end
    chk("wdog_change15", int'(fault_seen), 0);
    // Last change captured at edge k; counter hits 16 at k+17, fault at k+18.
    repeat (3) tick();
    chk("wdog_before", int'(fault), 0);
    tick();
    chk_fault("wdog", 1, 5, 0);
`else
    // Legal N/E cycle.
    fault_seen = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int d = 0; d < 2; d++) begin
        lamps[d] = G; repeat (10) tick();
        lamps[d] = Y; repeat (3) tick();
        lamps[d] = R; tick();
      end
    end
    repeat (3) tick();
    chk("legal_cycle", int'(fault_seen), 0);

    // Conflict N/E green, two-cycle latency, then flashing.
    lamps[0] = G; lamps[1] = G;
    tick();
    chk("conflict_latency", int'(fault), 0);
    tick();
    chk_fault("conflict", 1, 1, 0);
    chk("conflict_flash_on", int'(flash_red), 1);
    repeat (7) tick();
    chk("flash_hold", int'(flash_red), 1);
    tick();
    chk("flash_toggle", int'(flash_red), 0);

    // Clear while the conflict persists: violation wins.
    pulse_clear();
    chk("clear_blocked_fault", int'(fault), 1);
    chk("clear_blocked_code", int'(fault_code), 1);

    // Return to legal lamps and clear.
    lamps[0] = Y; lamps[1] = Y;
    repeat (3) tick();
    all_red();
    repeat (3) tick();
    pulse_clear();
    chk_fault("clear_ok", 0, 0, 0);
    chk("clear_ok_flash", int'(flash_red), 0);

    // Invalid W (green+red), then a later sequence error must not overwrite.
    lamps[3] = 3'b101;
    tick(); tick();
    chk_fault("invalid_w", 1, 2, 3);
    lamps[3] = R;
    tick(); tick();
    chk("no_overwrite_code", int'(fault_code), 2);

    // Reset mid-fault.
    reset = 1'b1;
    tick();
    chk_fault("reset_mid", 0, 0, 0);
    chk("reset_mid_flash", int'(flash_red), 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("after_reset_fault", int'(fault), 0);

    // S and W dark together: lowest index wins.
    lamps[2] = 3'b000; lamps[3] = 3'b000;
    tick(); tick();
    chk_fault("invalid_s", 1, 2, 2);
    all_red();
    repeat (3) tick();
    pulse_clear();
    chk("invalid_s_cleared", int'(fault), 0);

    // E green -> red directly.
    lamps[1] = G; repeat (3) tick();
    lamps[1] = R;
    tick();
    chk("seq_latency", int'(fault), 0);
    tick();
    chk_fault("seq_e", 1, 3, 1);
    repeat (2) tick();
    pulse_clear();
    chk("seq_cleared", int'(fault), 0);

    // S yellow for 2 cycles only.
    lamps[2] = G; repeat (3) tick();
    lamps[2] = Y; repeat (2) tick();
    lamps[2] = R;
    tick(); tick();
    chk_fault("short_yel_s", 1, 4, 2);
    repeat (2) tick();
    pulse_clear();
    chk("short_cleared", int'(fault), 0);

    // S yellow for exactly 3 cycles is legal.
    fault_seen = 1'b0;
    lamps[2] = G; repeat (3) tick();
    lamps[2] = Y; repeat (3) tick();
    lamps[2] = R; repeat (4) tick();
    chk("yellow_exact3", int'(fault_seen), 0);

    // Conflict outranks invalid on W.
    lamps[0] = G; lamps[3] = 3'b110;
    tick(); tick();
    chk_fault("prio_conflict", 1, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
